// File: rtl/nonce_result_scan.sv
// rtl/nonce_result_scan.sv - scans NUM_NONCES hash words for values below target
// Optional macro NONCE_SCAN_BEST_TRACK_EN enables minimum-word (best_hash/best_idx) tracking.
module nonce_result_scan #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [31:0] target,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        done,
  output logic        found,
  output logic [7:0]  nonce_idx,
  output logic [8:0]  match_count,
  output logic [31:0] best_hash,
  output logic [7:0]  best_idx
);

  typedef enum logic [1:0] {IDLE, FETCH, SCAN} state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_NONCES - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] target_q;
  logic [7:0]  idx;
  logic        accept;
  logic        in_scan;
  logic        hit;
  logic        last;

  assign mem_clk = clk;
  assign mem_we  = 1'b0;

  assign accept  = (state == IDLE) && start;
  assign in_scan = (state == SCAN);
  assign hit     = in_scan && (mem_read_data < target_q);
  assign last    = in_scan && (idx == LAST_IDX);

  // State register; reset aborts any scan in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state: one address-setup cycle, then one word per cycle until the last index.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = SCAN;
      SCAN:    if (idx == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address generation, match accumulation and the completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr    <= 16'h0000;
      done        <= 1'b0;
      found       <= 1'b0;
      nonce_idx   <= 8'h00;
      match_count <= 9'h000;
      target_q    <= 32'h0000_0000;
      idx         <= 8'h00;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mem_addr    <= base_addr;
        target_q    <= target;
        found       <= 1'b0;
        nonce_idx   <= 8'h00;
        match_count <= 9'h000;
      end
      if (state == FETCH) begin
        mem_addr <= mem_addr + 16'h0001;
        idx      <= 8'h00;
      end
      if (in_scan) begin
        mem_addr <= mem_addr + 16'h0001;
        idx      <= idx + 8'h01;
        if (hit) begin
          match_count <= match_count + 9'h001;
          if (!found) begin
            found     <= 1'b1;
            nonce_idx <= idx;
          end
        end
        if (last) done <= 1'b1;
      end
    end
  end

`ifdef NONCE_SCAN_BEST_TRACK_EN
  // Running minimum; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_hash <= 32'h0000_0000;
      best_idx  <= 8'h00;
    end else if (accept) begin
      best_hash <= 32'hFFFF_FFFF;
      best_idx  <= 8'h00;
    end else if (in_scan && (mem_read_data < best_hash)) begin
      best_hash <= mem_read_data;
      best_idx  <= idx;
    end
  end
`else
  assign best_hash = 32'h0000_0000;
  assign best_idx  = 8'h00;
`endif

endmodule

// File: tb/tb_nonce_result_scan.sv
// tb/tb_nonce_result_scan.sv - scoreboard bench for nonce_result_scan with a RAM model
module tb_nonce_result_scan;

  localparam int N = 16;

  typedef struct {
    int          edge_no;
    logic        found;
    logic [7:0]  idx;
    logic [8:0]  cnt;
    logic [31:0] best;
    logic [7:0]  bidx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'h0;
  logic [31:0] target = 32'h0;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_read_data = 32'h0;
  logic        done;
  logic        found;
  logic [7:0]  nonce_idx;
  logic [8:0]  match_count;
  logic [31:0] best_hash;
  logic [7:0]  best_idx;

  logic [31:0] mem [0:65535];
  exp_t        sb [$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  nonce_result_scan #(.NUM_NONCES(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .target(target), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_read_data(mem_read_data), .done(done), .found(found),
    .nonce_idx(nonce_idx), .match_count(match_count), .best_hash(best_hash),
    .best_idx(best_idx)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency, plus an edge counter.
  always @(posedge clk) begin
    mem_read_data <= mem[mem_addr];
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: scan N words starting at base (16-bit wrap) by the matching rules.
  function automatic exp_t model(input logic [15:0] base, input logic [31:0] tgt, input int acc);
    exp_t e;
    logic [31:0] w;
    logic [31:0] mn;
    int          mi;
    e.edge_no = acc + N + 1;
    e.found = 1'b0; e.idx = 8'h0; e.cnt = 9'h0;
    mn = 32'hFFFF_FFFF; mi = 0;
    for (int k = 0; k < N; k++) begin
      w = mem[16'(base + 16'(k))];
      if (w < tgt) begin
        e.cnt = e.cnt + 9'd1;
        if (!e.found) begin
          e.found = 1'b1;
          e.idx = 8'(k);
        end
      end
      if (w < mn) begin
        mn = w;
        mi = k;
      end
    end
`ifdef NONCE_SCAN_BEST_TRACK_EN
    e.best = mn; e.bidx = 8'(mi);
`else
    e.best = 32'h0; e.bidx = 8'h0;
`endif
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done expected=no_done at edge %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_edge", cyc, e.edge_no);
        chk("found", {31'h0, found}, {31'h0, e.found});
        chk("nonce_idx", {24'h0, nonce_idx}, {24'h0, e.idx});
        chk("match_count", {23'h0, match_count}, {23'h0, e.cnt});
        chk("best_hash", best_hash, e.best);
        chk("best_idx", {24'h0, best_idx}, {24'h0, e.bidx});
        chk("mem_we", {31'h0, mem_we}, 32'h0);
      end
    end
  end

  task automatic fill(input logic [15:0] base, input logic [31:0] val);
    for (int k = 0; k < N; k++) mem[16'(base + 16'(k))] = val;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int t = 0; t < N + 10; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done expected=done", name);
    end
  endtask

  task automatic run_scan(input string name, input logic [15:0] base, input logic [31:0] tgt);
    @(negedge clk);
    base_addr = base;
    target = tgt;
    start = 1'b1;
    sb.push_back(model(base, tgt, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    base_addr = 16'($urandom);
    target = $urandom;
    wait_done(name);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_found"}, {31'h0, found}, 32'h0);
    chk({tag, "_nonce_idx"}, {24'h0, nonce_idx}, 32'h0);
    chk({tag, "_match_count"}, {23'h0, match_count}, 32'h0);
    chk({tag, "_best_hash"}, best_hash, 32'h0);
    chk({tag, "_best_idx"}, {24'h0, best_idx}, 32'h0);
    chk({tag, "_mem_addr"}, {16'h0, mem_addr}, 32'h0);
    chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
  endtask

  initial begin
    logic [15:0] b;
    logic [31:0] tg;
    int          acc;
    int          ndone;

    for (int a = 0; a < 65536; a++) mem[a] = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // No word below target.
    for (int k = 0; k < N; k++) mem[16'h0040 + 16'(k)] = 32'h8000_0000 + 32'(k);
    run_scan("all_above", 16'h0040, 32'h0001_0000);

    // Two matches, first kept for nonce_idx, smaller one for best.
    fill(16'h0100, 32'hFFFF_FFFF);
    mem[16'h0103] = 32'h0000_0100;
    mem[16'h0109] = 32'h0000_0050;
    run_scan("two_match", 16'h0100, 32'h0000_1000);

    // Address wrap: word at 0002 is nonce 10.
    fill(16'hFFF8, 32'h9000_0000);
    mem[16'h0002] = 32'h0000_0007;
    run_scan("wrap", 16'hFFF8, 32'h0000_1000);

    // Tie on minimum, all-ones words never match even against FFFFFFFF.
    fill(16'h0200, 32'hFFFF_FFFF);
    mem[16'h0205] = 32'h0000_0001;
    mem[16'h020C] = 32'h0000_0001;
    run_scan("tie", 16'h0200, 32'hFFFF_FFFF);

    // Zero target never matches.
    for (int k = 0; k < N; k++) mem[16'h0300 + 16'(k)] = 32'(k);
    run_scan("zero_target", 16'h0300, 32'h0000_0000);

    // Randomized scans.
    for (int r = 0; r < 12; r++) begin
      b = 16'($urandom);
      tg = ($urandom_range(0, 1) == 0) ? 32'h0000_1000 : $urandom;
      for (int k = 0; k < N; k++)
        mem[16'(b + 16'(k))] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8191)) : $urandom;
      run_scan("random", b, tg);
    end

    // Reset mid-scan: aborted run must not pulse done.
    fill(16'h0400, 32'h0000_0001);
    @(negedge clk);
    base_addr = 16'h0400;
    target = 32'h0000_1000;
    start = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 7) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_values("abort");
    @(negedge clk);
    reset_n = 1'b1;
    fill(16'h0500, 32'h7000_0000);
    mem[16'h050E] = 32'h0000_0003;
    run_scan("after_abort", 16'h0500, 32'h0000_1000);
    repeat (3) @(negedge clk);

    // start held high: back-to-back scans 18 cycles apart.
    b = 16'h0600;
    for (int k = 0; k < N; k++) mem[16'(b + 16'(k))] = $urandom_range(0, 65535);
    @(negedge clk);
    base_addr = b;
    target = 32'h0000_8000;
    start = 1'b1;
    acc = cyc + 1;
    for (int s = 0; s < 3; s++) sb.push_back(model(b, 32'h0000_8000, acc + 18 * s));
    ndone = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (done) ndone++;
      if (ndone == 3) break;
    end
    start = 1'b0;
    chk("b2b_done_count", 32'(ndone), 32'd3);

    repeat (25) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("hold_found", {31'h0, found}, {31'h0, model(b, 32'h0000_8000, 0).found});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
